// File: rtl/message_unpack.sv
`default_nettype none
// ============================================================================
// message_unpack : strips end marker, zero padding and length field from
// padded 512-bit blocks; emits original data words plus recovered bit length.
// Revision: 1.0
// ============================================================================
module message_unpack (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic         sync_rst,
  input  logic [511:0] data_in,
  input  logic         data_in_last,
  input  logic         data_in_valid,
  output logic         data_in_ready,
  output logic [511:0] data_out,
  output logic         data_out_last,
  output logic         data_out_valid,
  input  logic         data_out_ready,
  output logic [63:0]  size_out,
  output logic         size_err,
  output logic         size_valid,
  input  logic         size_ready
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RECV = 3'd1,
    ST_LAST = 3'd2,
    ST_DONE = 3'd3
  } state_t;

  state_t       state, state_nx;
  logic         rst_any;
  logic         rdy_q, rdy_nx;
  logic         out_valid_q, out_valid_nx;
  logic [511:0] out_data_nx;
  logic         out_last_nx;
  logic         size_valid_q, size_valid_nx;
  logic [63:0]  size_nx;
  logic         size_err_nx;
  logic [511:0] hold_data, hold_nx;
  logic         hold_valid, hold_valid_nx;
  logic [54:0]  rcnt, rcnt_nx;
  logic [63:0]  len_q, len_nx;
  logic         err_q, err_nx;

  logic [8:0]   r;
  logic [8:0]   mpos;
  logic         extra;
  logic         marker_ok;
  logic         len_err;
  logic [55:0]  exp_cnt;
  logic [55:0]  got_cnt;
  logic [511:0] mask;
  logic         in_xfer, out_xfer, size_xfer;

  assign rst_any        = !nrst || sync_rst;
  assign data_in_ready  = en && rdy_q && (!out_valid_q || data_out_ready);
  assign data_out_valid = en && out_valid_q;
  assign size_valid     = en && size_valid_q;
  assign in_xfer        = data_in_valid && data_in_ready;
  assign out_xfer       = data_out_valid && data_out_ready;
  assign size_xfer      = size_valid && size_ready;

  // Final-block decode: residue r sets how many data bits survive in the
  // last data word; the marker sits just below them.
  assign r         = data_in[8:0];
  assign mpos      = 9'd511 - r;
  assign extra     = (r == 9'd0) || (r >= 9'd448);
  assign exp_cnt   = {1'b0, data_in[63:9]} + {55'd0, |r} + {55'd0, extra};
  assign got_cnt   = {1'b0, rcnt} + 56'd1;
  assign mask      = (r == 9'd0) ? {512{1'b1}} : ~({512{1'b1}} >> r);
  assign marker_ok = !extra       ? data_in[mpos]   :
                     (r != 9'd0)  ? hold_data[mpos] : data_in[511];
  assign len_err   = (got_cnt != exp_cnt) || !marker_ok;

  always_comb begin
    state_nx      = state;
    rdy_nx        = rdy_q;
    hold_nx       = hold_data;
    hold_valid_nx = hold_valid;
    rcnt_nx       = rcnt;
    out_data_nx   = data_out;
    out_last_nx   = data_out_last;
    out_valid_nx  = out_valid_q && !out_xfer;
    size_nx       = size_out;
    size_err_nx   = size_err;
    size_valid_nx = size_valid_q && !size_xfer;
    len_nx        = len_q;
    err_nx        = err_q;
    case (state)
      ST_IDLE: begin
        rdy_nx   = 1'b1;
        state_nx = ST_RECV;
      end
      ST_RECV: begin
        if (in_xfer) begin
          if (!data_in_last) begin
            if (hold_valid) begin
              out_data_nx  = hold_data;
              out_last_nx  = 1'b0;
              out_valid_nx = 1'b1;
            end
            hold_nx       = data_in;
            hold_valid_nx = 1'b1;
            if (rcnt != {55{1'b1}}) rcnt_nx = rcnt + 55'd1;
          end else begin
            hold_nx       = '0;
            hold_valid_nx = 1'b0;
            rdy_nx        = 1'b0;
            state_nx      = ST_DONE;
            if (data_in[63:0] == 64'd0) begin
              size_nx       = data_in[63:0];
              size_err_nx   = len_err;
              size_valid_nx = 1'b1;
            end else if (extra) begin
              // Final block carries only the length; the held word ends the data.
              out_data_nx   = hold_valid ? (hold_data & mask) : '0;
              out_last_nx   = 1'b1;
              out_valid_nx  = 1'b1;
              size_nx       = data_in[63:0];
              size_err_nx   = len_err;
              size_valid_nx = 1'b1;
            end else if (hold_valid) begin
              out_data_nx   = hold_data;
              out_last_nx   = 1'b0;
              out_valid_nx  = 1'b1;
              hold_nx       = data_in & mask;
              hold_valid_nx = 1'b1;
              len_nx        = data_in[63:0];
              err_nx        = len_err;
              state_nx      = ST_LAST;
            end else begin
              out_data_nx   = data_in & mask;
              out_last_nx   = 1'b1;
              out_valid_nx  = 1'b1;
              size_nx       = data_in[63:0];
              size_err_nx   = len_err;
              size_valid_nx = 1'b1;
            end
          end
        end
      end
      ST_LAST: begin
        if (!out_valid_q || out_xfer) begin
          out_data_nx   = hold_data;
          out_last_nx   = 1'b1;
          out_valid_nx  = 1'b1;
          size_nx       = len_q;
          size_err_nx   = err_q;
          size_valid_nx = 1'b1;
          hold_nx       = '0;
          hold_valid_nx = 1'b0;
          state_nx      = ST_DONE;
        end
      end
      ST_DONE: begin
        if ((!out_valid_q || out_xfer) && (!size_valid_q || size_xfer)) begin
          rcnt_nx  = '0;
          rdy_nx   = 1'b1;
          state_nx = ST_RECV;
        end
      end
      default: begin
        rdy_nx   = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_any)  state <= ST_IDLE;
    else if (en)  state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst_any) begin
      rdy_q         <= 1'b0;
      data_out      <= '0;
      data_out_last <= 1'b0;
      out_valid_q   <= 1'b0;
      size_out      <= '0;
      size_err      <= 1'b0;
      size_valid_q  <= 1'b0;
      hold_data     <= '0;
      hold_valid    <= 1'b0;
      rcnt          <= '0;
      len_q         <= '0;
      err_q         <= 1'b0;
    end else if (en) begin
      rdy_q         <= rdy_nx;
      data_out      <= out_data_nx;
      data_out_last <= out_last_nx;
      out_valid_q   <= out_valid_nx;
      size_out      <= size_nx;
      size_err      <= size_err_nx;
      size_valid_q  <= size_valid_nx;
      hold_data     <= hold_nx;
      hold_valid    <= hold_valid_nx;
      rcnt          <= rcnt_nx;
      len_q         <= len_nx;
      err_q         <= err_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_message_unpack.sv
`default_nettype none
// ============================================================================
// tb_message_unpack : directed stimulus with a message-level reference model.
// Revision: 1.0
// ============================================================================
module tb_message_unpack;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         en = 1'b1;
  logic         sync_rst = 1'b0;
  logic [511:0] data_in = '0;
  logic         data_in_last = 1'b0;
  logic         data_in_valid = 1'b0;
  logic         data_in_ready;
  logic [511:0] data_out;
  logic         data_out_last;
  logic         data_out_valid;
  logic         data_out_ready = 1'b1;
  logic [63:0]  size_out;
  logic         size_err;
  logic         size_valid;
  logic         size_ready = 1'b1;

  message_unpack dut (
    .clk            (clk),
    .nrst           (nrst),
    .en             (en),
    .sync_rst       (sync_rst),
    .data_in        (data_in),
    .data_in_last   (data_in_last),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_last  (data_out_last),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .size_out       (size_out),
    .size_err       (size_err),
    .size_valid     (size_valid),
    .size_ready     (size_ready)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed { logic [511:0] d; logic last; } wrd_t;
  typedef struct packed { logic [63:0] s; logic e; } sz_t;

  wrd_t         exp_w[$];
  wrd_t         got_w[$];
  sz_t          exp_s[$];
  sz_t          got_s[$];
  logic [511:0] cur[$];
  int           passed = 0;
  int           total = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: derive the expected words and size record of the message in cur.
  task automatic model_msg();
    int           n;
    int           r;
    logic [63:0]  s;
    logic [63:0]  t;
    logic [511:0] mask;
    logic [511:0] blk;
    bit           extra;
    bit           mk;
    wrd_t         w;
    sz_t          z;
    n     = cur.size();
    blk   = cur[n-1];
    s     = blk[63:0];
    r     = int'(s[8:0]);
    extra = (r == 0) || (r >= 448);
    mask  = '0;
    if (r == 0) mask = '1;
    else for (int i = 0; i < r; i++) mask[511-i] = 1'b1;
    t = (s >> 9) + 64'(r != 0) + 64'(extra);
    if (!extra) mk = blk[511-r];
    else if (r == 0) mk = blk[511];
    else if (n >= 2) begin blk = cur[n-2]; mk = blk[511-r]; end
    else mk = 1'b0;
    if (s != 64'd0) begin
      if (extra && n == 1) begin
        w.d = '0; w.last = 1'b1; exp_w.push_back(w);
      end else begin
        for (int i = 0; i < n - 2; i++) begin
          w.d = cur[i]; w.last = 1'b0; exp_w.push_back(w);
        end
        if (extra) begin
          w.d = cur[n-2] & mask; w.last = 1'b1; exp_w.push_back(w);
        end else begin
          if (n >= 2) begin w.d = cur[n-2]; w.last = 1'b0; exp_w.push_back(w); end
          w.d = cur[n-1] & mask; w.last = 1'b1; exp_w.push_back(w);
        end
      end
    end
    z.s = s;
    z.e = (64'(n) != t) || !mk;
    exp_s.push_back(z);
  endtask

  task automatic send_block(input logic [511:0] b, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    data_in = b; data_in_last = last; data_in_valid = 1'b1;
    #2;
    while (!data_in_ready && n < 300) begin
      @(negedge clk); #2; n++;
    end
    chk("block_accepted", 512'(data_in_ready), 512'(1));
    if (data_in_ready) @(posedge clk);
  endtask

  task automatic send_msg();
    model_msg();
    for (int i = 0; i < cur.size(); i++) send_block(cur[i], i == cur.size() - 1);
    @(negedge clk);
    data_in_valid = 1'b0; data_in_last = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_w.size() != 0 || exp_s.size() != 0 || data_out_valid || size_valid) && n < 300) begin
      @(negedge clk); #4; n++;
    end
    chk(name, 512'(exp_w.size() + exp_s.size()), 512'(0));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},  512'(data_in_ready), 512'(0));
    chk({tag, "_out_valid"}, 512'(data_out_valid), 512'(0));
    chk({tag, "_size_valid"},512'(size_valid), 512'(0));
    chk({tag, "_data_out"},  data_out, 512'(0));
    chk({tag, "_out_last"},  512'(data_out_last), 512'(0));
    chk({tag, "_size_out"},  512'(size_out), 512'(0));
    chk({tag, "_size_err"},  512'(size_err), 512'(0));
  endtask

  task automatic reset_mid(input bit use_sync, input logic [511:0] b);
    send_block(b, 1'b0);
    @(negedge clk);
    data_in_valid = 1'b0;
    if (use_sync) sync_rst = 1'b1; else nrst = 1'b0;
    @(negedge clk); #4;
    check_reset(use_sync ? "srst" : "nrst");
    sync_rst = 1'b0; nrst = 1'b1;
  endtask

  // Compare process: model queues on transfers, plus handshake invariants.
  initial begin : mon
    logic         pv, ps;
    logic [511:0] pd;
    logic         pl;
    logic [63:0]  pss;
    wrd_t         w;
    sz_t          z;
    pv = 1'b0; ps = 1'b0; pd = '0; pl = 1'b0; pss = '0;
    forever begin
      @(negedge clk); #3;
      if (!nrst || sync_rst) begin
        pv = 1'b0; ps = 1'b0;
      end else if (!en) begin
        chk("en_gate", 512'({data_in_ready, data_out_valid, size_valid}), 512'(0));
      end else begin
        if (pv) begin
          chk("out_stable_v", 512'(data_out_valid), 512'(1));
          chk("out_stable_d", data_out, pd);
          chk("out_stable_l", 512'(data_out_last), 512'(pl));
        end
        if (ps) begin
          chk("size_stable_v", 512'(size_valid), 512'(1));
          chk("size_stable_s", 512'(size_out), 512'(pss));
        end
        if (data_out_valid && !data_out_ready) chk("stall_in_ready", 512'(data_in_ready), 512'(0));
        if (size_valid) chk("size_pending_in_ready", 512'(data_in_ready), 512'(0));
        if (data_out_valid && data_out_ready) begin
          w.d = data_out; w.last = data_out_last;
          got_w.push_back(w);
          chk("word_expected", 512'(exp_w.size() != 0), 512'(1));
          if (exp_w.size() != 0) begin
            chk("word_data", data_out, exp_w[0].d);
            chk("word_last", 512'(data_out_last), 512'(exp_w[0].last));
            void'(exp_w.pop_front());
          end
        end
        if (size_valid && size_ready) begin
          z.s = size_out; z.e = size_err;
          got_s.push_back(z);
          chk("size_expected", 512'(exp_s.size() != 0), 512'(1));
          if (exp_s.size() != 0) begin
            chk("size_out", 512'(size_out), 512'(exp_s[0].s));
            chk("size_err", 512'(size_err), 512'(exp_s[0].e));
            void'(exp_s.pop_front());
          end
        end
        pv = data_out_valid && !data_out_ready; pd = data_out; pl = data_out_last;
        ps = size_valid && !size_ready; pss = size_out;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic [511:0] msg24, pa, pb, lit;
    int n;
    msg24 = {24'h616263, 1'b1, 423'd0, 64'd24};
    pa    = {16{32'hA5A50001}};
    pb    = {16{32'h5A5A0FF2}};

    repeat (3) @(negedge clk);
    #4 check_reset("por");
    nrst = 1'b1;
    n = 0;
    while (!data_in_ready && n < 5) begin @(negedge clk); #4; n++; end
    chk("ready_after_reset", 512'(data_in_ready), 512'(1));

    // S=24: single block
    cur.delete(); cur.push_back(msg24);
    send_msg(); wait_idle("idle_s24");
    lit = '0; lit[511:488] = 24'h616263;
    chk("lit_s24_word", got_w[got_w.size()-1].d, lit);
    chk("lit_s24_last", 512'(got_w[got_w.size()-1].last), 512'(1));
    chk("lit_s24_size", 512'(got_s[got_s.size()-1].s), 512'(24));
    chk("lit_s24_err",  512'(got_s[got_s.size()-1].e), 512'(0));

    // S=1024: length-only extra block
    cur.delete(); cur.push_back(pa); cur.push_back(pb);
    cur.push_back({1'b1, 447'd0, 64'd1024});
    send_msg(); wait_idle("idle_s1024");
    chk("lit_s1024_prev", got_w[got_w.size()-2].d, pa);
    chk("lit_s1024_word", got_w[got_w.size()-1].d, pb);
    chk("lit_s1024_last", 512'(got_w[got_w.size()-1].last), 512'(1));

    // S=960: r=448, marker in the held block
    cur.delete(); cur.push_back(pa);
    cur.push_back({{14{32'hC3C31234}}, 64'h8000_0000_0000_0000});
    cur.push_back({448'd0, 64'd960});
    send_msg(); wait_idle("idle_s960");
    chk("lit_s960_word", got_w[got_w.size()-1].d, {{14{32'hC3C31234}}, 64'd0});
    chk("lit_s960_err",  512'(got_s[got_s.size()-1].e), 512'(0));

    // S=600 with downstream stalls, then a back-to-back message
    cur.delete(); cur.push_back(pb);
    cur.push_back({88'h112233445566778899AABB, 1'b1, 359'd0, 64'd600});
    fork
      send_msg();
      begin @(negedge clk); data_out_ready = 1'b0; repeat (5) @(negedge clk); data_out_ready = 1'b1; end
      begin : szs
        int k;
        k = 0; size_ready = 1'b0;
        while (!size_valid && k < 100) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        size_ready = 1'b1;
      end
    join
    cur.delete(); cur.push_back(msg24);
    send_msg(); wait_idle("idle_s600");
    chk("lit_s600_word", got_w[got_w.size()-2].d, {88'h112233445566778899AABB, 424'd0});
    chk("lit_s600_size", 512'(got_s[got_s.size()-2].s), 512'(600));

    // Length claims 2048 bits but only two blocks arrive
    cur.delete(); cur.push_back(pa); cur.push_back({1'b1, 447'd0, 64'd2048});
    send_msg(); wait_idle("idle_err");
    chk("lit_err_flag", 512'(got_s[got_s.size()-1].e), 512'(1));
    chk("lit_err_last", 512'(got_w[got_w.size()-1].last), 512'(1));

    // Zero-length message: no data word, only the size record
    n = got_w.size();
    cur.delete(); cur.push_back({1'b1, 447'd0, 64'd0});
    send_msg(); wait_idle("idle_s0");
    chk("lit_s0_nowords", 512'(got_w.size()), 512'(n));

    // Mid-message resets, each followed by a clean S=24 message
    reset_mid(1'b0, pa);
    cur.delete(); cur.push_back(msg24);
    send_msg(); wait_idle("idle_after_nrst");
    reset_mid(1'b1, pb);
    cur.delete(); cur.push_back(msg24);
    send_msg(); wait_idle("idle_after_srst");

    // Enable low for 4 cycles in the middle of an S=1024 message
    data_out_ready = 1'b0;
    cur.delete(); cur.push_back(pb); cur.push_back(pa);
    cur.push_back({1'b1, 447'd0, 64'd1024});
    fork
      send_msg();
      begin : engap
        logic [511:0] snap;
        repeat (3) @(negedge clk);
        en = 1'b0; snap = data_out;
        repeat (4) @(negedge clk);
        chk("en_freeze_data", data_out, snap);
        en = 1'b1;
        repeat (2) @(negedge clk);
        data_out_ready = 1'b1;
      end
    join
    wait_idle("idle_en");
    chk("lit_en_word", got_w[got_w.size()-1].d, pa);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
